fp_compare_issue: RTL and testbench

Issue and completion controller for the fixed-latency `fp_compare` pipeline. It accepts FP compare micro-ops (FLT/FLE/FEQ) with a tag over a valid/ready handshake and drives `fp_compare` operands. It tracks in-flight ops in a shadow valid/tag pipe aligned to the compare latency, applies RISC-V NaN semantics, and returns results to writeback through a credit-protected result queue. The compare pipe cannot stall, so issue is gated by free queue credits.

---
 rtl/fp_compare_issue_if.sv | 47 ++++
 rtl/fp_compare_issue.sv | 149 ++++++++++++++
 tb/tb_fp_compare_issue.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_compare_issue_if.sv
// Compare-op type plus the issue/compare/writeback signal bundle of fp_compare_issue.
// slave = controller side, master = environment (issue stage, fp_compare, writeback).
package fp_compare_issue_pkg;
  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_LE = 2'd1,
    CMP_EQ = 2'd2
  } fp_cmp_t;
endpackage

interface fp_compare_issue_if #(
  parameter int W     = 32,
  parameter int TAG_W = 6
);
  logic                          in_valid;
  logic                          in_ready;
  logic [W-1:0]                  in_a;
  logic [W-1:0]                  in_b;
  fp_compare_issue_pkg::fp_cmp_t in_type;
  logic [TAG_W-1:0]              in_tag;
  logic [31:0]                   in_pc;

  logic                          cmp_start;
  logic [W-1:0]                  cmp_a;
  logic [W-1:0]                  cmp_b;
  fp_compare_issue_pkg::fp_cmp_t cmp_type;
  logic [31:0]                   cmp_pc;
  logic                          cmp_y;

  logic                          out_valid;
  logic                          out_ready;
  logic [TAG_W-1:0]              out_tag;
  logic                          out_y;
  logic                          out_nv;

  modport slave (
    input  in_valid, in_a, in_b, in_type, in_tag, in_pc, cmp_y, out_ready,
    output in_ready, cmp_start, cmp_a, cmp_b, cmp_type, cmp_pc,
    output out_valid, out_tag, out_y, out_nv
  );

  modport master (
    output in_valid, in_a, in_b, in_type, in_tag, in_pc, cmp_y, out_ready,
    input  in_ready, cmp_start, cmp_a, cmp_b, cmp_type, cmp_pc,
    input  out_valid, out_tag, out_y, out_nv
  );
endinterface

// File: rtl/fp_compare_issue.sv
// Issue/completion controller for the non-stallable fp_compare pipe, credit-gated by the result queue.
// Define FP_CMP_BYPASS_EN to present a result combinationally (latency D) when the queue is empty.
module fp_compare_issue #(
  parameter int W     = 32,
  parameter int D     = 4,
  parameter int TAG_W = 6,
  parameter int Q     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  fp_compare_issue_if.slave bus,
  output logic              busy
);
  localparam int EW = (W == 64) ? 11 : 8;
  localparam int MW = W - 1 - EW;
  localparam int PW = (Q > 1) ? $clog2(Q) : 1;
  localparam int CW = $clog2(Q + 1);
  localparam int IW = $clog2(D + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             y;
    logic             nv;
  } res_t;

  logic             accept;
  logic             credit_ok;
  logic [IW-1:0]    inflight;
  logic             a_nan, b_nan, a_snan, b_snan;
  logic             f0_acc, nv_acc;
  logic [D-1:0]     sv_q, sv_d, sf0_q, snv_q;
  logic [TAG_W-1:0] stag_q [D];
  res_t             mem_q [Q];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done, q_valid, byp, enq, deq;
  res_t             done_res, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Q - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < D; i++) inflight = inflight + IW'(sv_q[i]);
  end

  // Credits count ops still in the compare pipe, since that pipe cannot be stalled.
  assign credit_ok    = (int'(inflight) + int'(cnt_q)) < Q;
  assign bus.in_ready = !flush && credit_ok;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.cmp_start = accept;
  assign bus.cmp_a     = bus.in_a;
  assign bus.cmp_b     = bus.in_b;
  assign bus.cmp_type  = bus.in_type;
  assign bus.cmp_pc    = bus.in_pc;

  assign a_nan  = (&bus.in_a[W-2 -: EW]) && (|bus.in_a[MW-1:0]);
  assign b_nan  = (&bus.in_b[W-2 -: EW]) && (|bus.in_b[MW-1:0]);
  assign a_snan = a_nan && !bus.in_a[MW-1];
  assign b_snan = b_nan && !bus.in_b[MW-1];
  assign f0_acc = a_nan || b_nan;
  assign nv_acc = (bus.in_type == fp_compare_issue_pkg::CMP_EQ) ? (a_snan || b_snan) : f0_acc;

  always_comb begin
    sv_d = '0;
    if (!flush) begin
      sv_d[0] = accept;
      for (int i = 1; i < D; i++) sv_d[i] = sv_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sv_q  <= '0;
      sf0_q <= '0;
      snv_q <= '0;
      for (int i = 0; i < D; i++) stag_q[i] <= '0;
    end else begin
      sv_q      <= sv_d;
      sf0_q[0]  <= f0_acc;
      snv_q[0]  <= nv_acc;
      stag_q[0] <= bus.in_tag;
      for (int i = 1; i < D; i++) begin
        sf0_q[i]  <= sf0_q[i-1];
        snv_q[i]  <= snv_q[i-1];
        stag_q[i] <= stag_q[i-1];
      end
    end
  end

  assign done = sv_q[D-1];

  always_comb begin
    done_res.tag = stag_q[D-1];
    done_res.y   = bus.cmp_y & ~sf0_q[D-1];
    done_res.nv  = snv_q[D-1];
  end

  assign q_valid = (cnt_q != '0);
  assign head    = mem_q[rd_q];

`ifdef FP_CMP_BYPASS_EN
  assign byp = done && !q_valid;
`else
  assign byp = 1'b0;
`endif

  assign deq = q_valid && bus.out_ready;
  assign enq = done && !(byp && bus.out_ready);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq) wr_d = ptr_inc(wr_q);
      if (deq) rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < Q; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (enq && !flush) mem_q[wr_q] <= done_res;
    end
  end

  assign bus.out_valid = q_valid || byp;
  assign bus.out_tag   = byp ? done_res.tag : head.tag;
  assign bus.out_y     = byp ? done_res.y   : head.y;
  assign bus.out_nv    = byp ? done_res.nv  : head.nv;

  assign busy = (|sv_q) || q_valid;
endmodule

// File: tb/tb_fp_compare_issue.sv
// Self-checking bench for fp_compare_issue: behavioural fp_compare pipe plus a result scoreboard.
module tb_fp_compare_issue;
  import fp_compare_issue_pkg::*;

  localparam int W     = 32;
  localparam int D     = 4;
  localparam int TAG_W = 6;
  localparam int Q     = 4;
`ifdef FP_CMP_BYPASS_EN
  localparam int LAT = D;
`else
  localparam int LAT = D + 1;
`endif

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             y;
    logic             nv;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic busy;
  int   checks   = 0;
  int   failures = 0;

  fp_compare_issue_if #(.W(W), .TAG_W(TAG_W)) bus ();

  fp_compare_issue #(.W(W), .D(D), .TAG_W(TAG_W), .Q(Q)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] okey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  // IEEE ordering of non-NaN values (+0 == -0).
  function automatic logic ord_cmp(input logic [31:0] a, input logic [31:0] b, input fp_cmp_t t);
    logic eq, lt;
    eq = (a == b) || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
    lt = !eq && (okey(a) < okey(b));
    case (t)
      CMP_LT:  return lt;
      CMP_LE:  return lt || eq;
      default: return eq;
    endcase
  endfunction

  function automatic exp_t ref_result(input logic [31:0] a, input logic [31:0] b,
                                      input fp_cmp_t t, input logic [TAG_W-1:0] tag);
    exp_t r;
    r.tag = tag;
    if (is_nan(a) || is_nan(b)) begin
      r.y  = 1'b0;
      r.nv = (t != CMP_EQ) || is_snan(a) || is_snan(b);
    end else begin
      r.y  = ord_cmp(a, b, t);
      r.nv = 1'b0;
    end
    return r;
  endfunction

  // Stand-in fp_compare: fixed latency D, never cleared, answers 1 on NaN inputs.
  logic [D-1:0] cpipe = '0;
  always @(posedge clk)
    cpipe <= {cpipe[D-2:0],
              (is_nan(bus.cmp_a) || is_nan(bus.cmp_b)) ? 1'b1 : ord_cmp(bus.cmp_a, bus.cmp_b, bus.cmp_type)};
  assign bus.cmp_y = cpipe[D-1];

  exp_t expq[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset_n || flush) begin
      expq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_unexpected got tag=%0d y=%0b nv=%0b, expected no result",
                   bus.out_tag, bus.out_y, bus.out_nv);
        end else begin
          mon_e = expq.pop_front();
          if ({bus.out_tag, bus.out_y, bus.out_nv} !== {mon_e.tag, mon_e.y, mon_e.nv}) begin
            failures++;
            $display("FAIL scoreboard_result got tag=%0d y=%0b nv=%0b, expected tag=%0d y=%0b nv=%0b",
                     bus.out_tag, bus.out_y, bus.out_nv, mon_e.tag, mon_e.y, mon_e.nv);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        expq.push_back(ref_result(bus.in_a, bus.in_b, bus.in_type, bus.in_tag));
    end
  end

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input fp_cmp_t t,
                       input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_type  = t;
    bus.in_tag   = tag;
    bus.in_pc    = $urandom;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] tbl [10];
    int          k;
    tbl = '{32'h3F80_0000, 32'h4000_0000, 32'h7FC0_0000, 32'h7F80_0001, 32'h8000_0000,
            32'h0000_0000, 32'hBF80_0000, 32'hC000_0000, 32'h7F80_0000, 32'hFF80_0000};
    k = $urandom_range(0, 13);
    return (k < 10) ? tbl[k] : $urandom;
  endfunction

  task automatic test_reset();
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_type   = CMP_LT;
    bus.in_tag    = '0;
    bus.in_pc     = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bus.out_tag !== '0)     begin failures++; $display("FAIL reset_out_tag got %0d want 0", bus.out_tag); end
    checks++; if (bus.out_y !== 1'b0)     begin failures++; $display("FAIL reset_out_y got %b want 0", bus.out_y); end
    checks++; if (bus.out_nv !== 1'b0)    begin failures++; $display("FAIL reset_out_nv got %b want 0", bus.out_nv); end
  endtask

  task automatic test_latency();
    int               lat = 0;
    logic [TAG_W-1:0] t_tag = '0;
    logic             t_y = 1'bx, t_nv = 1'bx;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    offer(32'h3F80_0000, 32'h4000_0000, CMP_LT, 6'd5);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL latency_accept got in_ready=%b want 1", bus.in_ready); end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k; t_tag = bus.out_tag; t_y = bus.out_y; t_nv = bus.out_nv;
        break;
      end
    end
    checks++; if (lat != LAT)     begin failures++; $display("FAIL latency_cycles got %0d want %0d", lat, LAT); end
    checks++; if (t_tag !== 6'd5) begin failures++; $display("FAIL latency_tag got %0d want 5", t_tag); end
    checks++; if (t_y !== 1'b1)   begin failures++; $display("FAIL latency_y got %b want 1", t_y); end
    checks++; if (t_nv !== 1'b0)  begin failures++; $display("FAIL latency_nv got %b want 0", t_nv); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_nan_cases();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    fp_cmp_t     vt [5];
    logic        ey [5];
    logic        env [5];
    logic        gy, gnv;
    va  = '{32'h7FC0_0000, 32'h7F80_0001, 32'h7FC0_0000, 32'h8000_0000, 32'hBF80_0000};
    vb  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'hC000_0000};
    vt  = '{CMP_EQ, CMP_EQ, CMP_LE, CMP_EQ, CMP_LT};
    ey  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    env = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      offer(va[i], vb[i], vt[i], TAG_W'(20 + i));
      @(posedge clk); #1 bus.in_valid = 1'b0;
      gy = 1'bx; gnv = 1'bx;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.out_valid) begin gy = bus.out_y; gnv = bus.out_nv; break; end
      end
      checks++; if (gy !== ey[i])   begin failures++; $display("FAIL special_y case %0d got %b want %b", i, gy, ey[i]); end
      checks++; if (gnv !== env[i]) begin failures++; $display("FAIL special_nv case %0d got %b want %b", i, gnv, env[i]); end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int drained = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      offer(32'h3F80_0000 + 32'($urandom_range(0, 4095)), 32'h3F80_0800, CMP_LE, TAG_W'(10 + i));
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (acc != Q)              begin failures++; $display("FAIL bp_accepted got %0d want %0d", acc, Q); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    checks++; if (busy !== 1'b1)         begin failures++; $display("FAIL bp_busy got %b want 1", busy); end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) drained++;
      if (!busy) break;
    end
    checks++; if (drained != Q)     begin failures++; $display("FAIL bp_drained got %0d want %0d", drained, Q); end
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL bp_leftover got %0d want 0", expq.size()); end
  endtask

  task automatic test_flush();
    int  acc = 0;
    logic seen = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(32'h3F80_0000, 32'h4000_0000, CMP_LT, TAG_W'(40 + i));
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (acc != 3)              begin failures++; $display("FAIL flush_accepted got %0d want 3", acc); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_stale_result got out_valid=1 want none"); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 59) == 0);
      offer(pick_operand(), pick_operand(), fp_cmp_t'($urandom_range(0, 2)), TAG_W'($urandom));
      bus.in_valid  = ($urandom_range(0, 1) != 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL random_drain_busy got %b want 0", busy); end
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL random_lost_results got %0d want 0", expq.size()); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    offer(32'h3F80_0000, 32'h4000_0000, CMP_LT, 6'd50);
    @(posedge clk); #1 offer(32'h4000_0000, 32'h3F80_0000, CMP_LT, 6'd51);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (D + 1) @(posedge clk);
    #1 offer(32'h3F80_0000, 32'h3F80_0000, CMP_EQ, 6'd52);
    @(posedge clk); #1 offer(32'h3F80_0000, 32'h3F80_0000, CMP_LE, 6'd53);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(posedge clk); #1;
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_ghost_result got out_valid=1 want none"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_nan_cases();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
